// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling
// and the baud divider calculation used by both RX and TX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE_DEF = 16;

  // Integer-truncated clocks per oversampling tick.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator: one-clock pulse every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled with mid-bit sampling.
// rx_done / frame_err are single-clock strobes; rx_data holds the last good byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err,
  output logic [2:0] o_state
);

  localparam int            DIV       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

  logic          r_sync1, r_sync2;
  uart_state_t   r_state, w_state_nxt;
  logic [TW-1:0] r_tick_cnt, w_tick_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic [7:0]    r_shreg, w_shreg_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_done, w_done_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          w_tick;
  logic          w_rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shreg    <= w_shreg_nxt;
      r_data     <= w_data_nxt;
      r_done     <= w_done_nxt;
      r_ferr     <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_tick_nxt  = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_tick_cnt == HALF_LAST) begin
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_shreg_nxt = {w_rx_s, r_shreg[7:1]};
            w_tick_nxt  = '0;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 3'd1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        // Leaving mid stop bit lets a start bit that follows immediately be caught.
        if (w_tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_nxt = '0;
            if (w_rx_s) begin
              w_data_nxt  = r_shreg;
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = WAIT_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
      WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign rx_data   = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_ferr;
  assign rx_busy   = (r_state != IDLE);
  assign o_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner sequences,
// and randomized frames against a frame-level reference model.
module tb_uart_rx;
  import uart_pkg::*;

  // Fast line rate keeps the run short: DIV = 4, one bit = 64 clocks = 640 time units.
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int OS       = 16;
  localparam int BIT_NS   = 640;
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_WAIT = WAIT_IDLE;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_ferr   = 0;
  int exp_ferr_total = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bit_ns;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .o_state   (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int ns);
    rx = b;
    #(ns);
  endtask

  // Start, 8 data bits LSB first, stop; line left at the stop level.
  task automatic send_bits(input logic [7:0] d, input logic stop, input int bit_ns);
    drive_bit(1'b0, bit_ns);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_ns);
    drive_bit(stop, bit_ns);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns);
    send_bits(d, stop, bit_ns);
    rx = 1'b1;
  endtask

  task automatic idle(input int ns);
    rx = 1'b1;
    #(ns);
  endtask

  // Scoreboard: every rx_done must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_done) begin
      n_done++;
      check("rx_done_expected", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("rx_data_at_done", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
    end
    if (frame_err) n_ferr++;
    if (rx_done || frame_err) check("done_ferr_exclusive", {31'b0, rx_done & frame_err}, 32'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, gap;
    logic [7:0] d, model_last;
    logic stop;

    vecs[0] = '{8'h52, 1'b1, BIT_NS, 8'h52, 1, 0};
    vecs[1] = '{8'h69, 1'b1, 652,    8'h69, 1, 0};  // ~2% slow
    vecs[2] = '{8'h69, 1'b1, 628,    8'h69, 1, 0};  // ~2% fast
    vecs[3] = '{8'h00, 1'b1, BIT_NS, 8'h00, 1, 0};
    vecs[4] = '{8'hA5, 1'b0, BIT_NS, 8'h00, 0, 1};
    vecs[5] = '{8'hFF, 1'b1, BIT_NS, 8'hFF, 1, 0};
    vecs[6] = '{8'h5A, 1'b0, BIT_NS, 8'hFF, 0, 1};

    rst = 1'b1;
    rx  = 1'b1;
    #23;
    check("reset_rx_data", {24'b0, rx_data}, 32'h00);
    check("reset_rx_done", {31'b0, rx_done}, 32'd0);
    check("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    check("reset_state", {29'b0, o_state}, {29'b0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      d0 = n_done;
      f0 = n_ferr;
      if (vecs[i].exp_done != 0) exp_q.push_back(vecs[i].exp_data);
      exp_ferr_total += vecs[i].exp_ferr;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_ns);
      idle(BIT_NS);
      check($sformatf("vec%0d_done", i), n_done - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i), {24'b0, rx_data}, {24'b0, vecs[i].exp_data});
      check($sformatf("vec%0d_busy", i), {31'b0, rx_busy}, 32'd0);
    end

    // Back-to-back frames with no idle between them.
    d0 = n_done;
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h4D);
    send_frame(8'h53, 1'b1, BIT_NS);
    send_frame(8'h4D, 1'b1, BIT_NS);
    idle(BIT_NS);
    check("b2b_done", n_done - d0, 2);
    check("b2b_data", {24'b0, rx_data}, 32'h4D);

    // Glitch shorter than half a bit: false start.
    d0 = n_done;
    f0 = n_ferr;
    rx = 1'b0;
    #150;
    check("glitch_busy_start", {31'b0, rx_busy}, 32'd1);
    #50;
    idle(2 * BIT_NS);
    check("glitch_busy_end", {31'b0, rx_busy}, 32'd0);
    check("glitch_state", {29'b0, o_state}, {29'b0, ST_IDLE});
    check("glitch_done", n_done - d0, 0);
    check("glitch_ferr", n_ferr - f0, 0);

    // Bad stop bit followed by a held-low line, then a good frame.
    d0 = n_done;
    f0 = n_ferr;
    exp_ferr_total++;
    send_bits(8'h48, 1'b0, BIT_NS);
    #(BIT_NS);
    check("break_state", {29'b0, o_state}, {29'b0, ST_WAIT});
    check("break_busy", {31'b0, rx_busy}, 32'd1);
    #(BIT_NS);
    idle(BIT_NS);
    check("break_ferr", n_ferr - f0, 1);
    check("break_done", n_done - d0, 0);
    check("break_data_held", {24'b0, rx_data}, 32'h4D);
    exp_q.push_back(8'h68);
    send_frame(8'h68, 1'b1, BIT_NS);
    idle(BIT_NS);
    check("after_break_done", n_done - d0, 1);
    check("after_break_data", {24'b0, rx_data}, 32'h68);

    // Reset in the middle of data bit 4, then a complete frame.
    d0 = n_done;
    d = 8'h43;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_NS);
    rx = d[4];
    #(BIT_NS / 2);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", {24'b0, rx_data}, 32'h00);
    check("midrst_rx_busy", {31'b0, rx_busy}, 32'd0);
    check("midrst_rx_done", {31'b0, rx_done}, 32'd0);
    check("midrst_state", {29'b0, o_state}, {29'b0, ST_IDLE});
    rx = 1'b1;
    #29;
    rst = 1'b0;
    idle(2 * BIT_NS);
    check("midrst_no_done", n_done - d0, 0);
    exp_q.push_back(8'h43);
    send_frame(8'h43, 1'b1, BIT_NS);
    idle(BIT_NS);
    check("midrst_done", n_done - d0, 1);
    check("midrst_data", {24'b0, rx_data}, 32'h43);

    // Random frames: a frame yields its byte iff its stop bit is high;
    // after a bad stop the line must return high before the next start.
    model_last = 8'h43;
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      if (stop) begin
        exp_q.push_back(d);
        model_last = d;
      end else begin
        exp_ferr_total++;
      end
      send_frame(d, stop, BIT_NS);
      gap = $urandom_range(stop ? 0 : 1, 3) * (BIT_NS / 4);
      if (gap > 0) idle(gap);
    end
    idle(2 * BIT_NS);
    check("rand_last_data", {24'b0, rx_data}, {24'b0, model_last});
    check("rand_busy", {31'b0, rx_busy}, 32'd0);

    check("all_frames_received", exp_q.size(), 0);
    check("frame_err_total", n_ferr, exp_ferr_total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
